// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: register control codes
// and the sequencer state encoding.
package booth_pkg;

   localparam logic [1:0] REG_LOAD = 2'b00;
   localparam logic [1:0] REG_CLR  = 2'b01;
   localparam logic [1:0] REG_SHR  = 2'b10;
   localparam logic [1:0] REG_HOLD = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StEval,
      StShift,
      StDone
   } booth_state_e;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Booth multiplier sequencer: runs WIDTH eval/shift iterations, owns the Q[-1]
// bit and the iteration counter, and signals completion with busy/done.
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       q0,
   output logic [1:0] a_ctrl,
   output logic [1:0] q_ctrl,
   output logic       m_load,
   output logic       alu_sub,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

   booth_state_e    state_q, state_d;
   logic            qm1_q, qm1_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CntW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      a_ctrl  = REG_HOLD;
      q_ctrl  = REG_HOLD;
      m_load  = 1'b0;
      alu_sub = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StInit;
         end
         StInit: begin
            a_ctrl  = REG_CLR;
            q_ctrl  = REG_LOAD;
            m_load  = 1'b1;
            busy    = 1'b1;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = StEval;
         end
         StEval: begin
            busy = 1'b1;
            unique case ({q0, qm1_q})
               2'b10: begin
                  a_ctrl  = REG_LOAD;
                  alu_sub = 1'b1;
               end
               2'b01: a_ctrl = REG_LOAD;
               default: a_ctrl = REG_HOLD;
            endcase
            state_d = StShift;
         end
         StShift: begin
            a_ctrl = REG_SHR;
            q_ctrl = REG_SHR;
            busy   = 1'b1;
            // q0 here is still the pre-shift LSB, i.e. next iteration's Q[-1].
            qm1_d  = q0;
            cnt_d  = cnt_inc;
            state_d = (cnt_inc == CntLast) ? StDone : StEval;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort cancels whatever transition was decoded; partial state is kept.
      if (abort) begin
         state_d = StIdle;
         qm1_d   = qm1_q;
         cnt_d   = cnt_q;
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural A/Q/M datapath model.
module tb_booth_seq_ctrl;
   import booth_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       q0;
   logic [1:0] a_ctrl, q_ctrl;
   logic       m_load, alu_sub, busy, done;

   logic [3:0] a_m = '0, q_m = '0, m_m = '0;
   logic [3:0] mplier = '0, mcand = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   booth_seq_ctrl #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .q0      (q0),
      .a_ctrl  (a_ctrl),
      .q_ctrl  (q_ctrl),
      .m_load  (m_load),
      .alu_sub (alu_sub),
      .busy    (busy),
      .done    (done)
   );

   assign q0 = q_m[0];

   always @(posedge clk) begin
      if (m_load) m_m <= mcand;
      case (a_ctrl)
         REG_LOAD: a_m <= alu_sub ? (a_m - m_m) : (a_m + m_m);
         REG_CLR:  a_m <= '0;
         REG_SHR:  a_m <= {a_m[3], a_m[3:1]};
         default:  ;
      endcase
      case (q_ctrl)
         REG_LOAD: q_m <= mplier;
         REG_CLR:  q_m <= '0;
         REG_SHR:  q_m <= {a_m[0], q_m[3:1]};
         default:  ;
      endcase
   end

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({a_ctrl, q_ctrl, m_load, alu_sub, busy, done} !== {REG_HOLD, REG_HOLD, 4'b0000}) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got a=%b q=%b m=%b s=%b busy=%b done=%b want 11 11 0 0 0 0",
                     i, a_ctrl, q_ctrl, m_load, alu_sub, busy, done);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_ctrl, q_ctrl, m_load, busy} !== {REG_CLR, REG_LOAD, 2'b11}) begin
         failures++;
         $display("FAIL reset_release_init got a=%b q=%b m=%b busy=%b want 01 00 1 1",
                  a_ctrl, q_ctrl, m_load, busy);
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({a_ctrl, q_ctrl, busy} !== {REG_HOLD, REG_HOLD, 1'b0}) begin
         failures++;
         $display("FAIL abort_from_init got a=%b q=%b busy=%b want 11 11 0", a_ctrl, q_ctrl, busy);
      end
      // start with abort or rst in IDLE must not launch a run
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      rst = 1'b1;
      checks++;
      if ({busy, m_load} !== 2'b00) begin
         failures++;
         $display("FAIL abort_with_start got busy=%b m_load=%b want 0 0", busy, m_load);
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checks++;
      if ({busy, m_load} !== 2'b00) begin
         failures++;
         $display("FAIL rst_with_start got busy=%b m_load=%b want 0 0", busy, m_load);
      end
   endtask

   // ops: 2 bits per EVAL, iteration 1 in [1:0]; 0 hold, 1 add, 2 sub.
   task automatic run_mul(input string name, input logic [3:0] mp, input logic [3:0] mc,
                          input logic [7:0] ops, input logic [7:0] exp_prod, input int start_at);
      int ndone;
      logic [1:0] op, exp_a;
      logic exp_s;
      @(negedge clk);
      mplier = mp;
      mcand = mc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 1) begin
            checks++;
            if ({a_ctrl, q_ctrl, m_load, busy, done} !== {REG_CLR, REG_LOAD, 3'b110}) begin
               failures++;
               $display("FAIL %s init got a=%b q=%b m=%b busy=%b done=%b want 01 00 1 1 0",
                        name, a_ctrl, q_ctrl, m_load, busy, done);
            end
         end else if (k <= 9 && (k % 2) == 0) begin
            op = ops[(k / 2 - 1) * 2 +: 2];
            exp_a = (op == 2'd0) ? REG_HOLD : REG_LOAD;
            exp_s = (op == 2'd2);
            checks++;
            if ({a_ctrl, q_ctrl, alu_sub, busy} !== {exp_a, REG_HOLD, exp_s, 1'b1}) begin
               failures++;
               $display("FAIL %s eval%0d got a=%b q=%b sub=%b busy=%b want %b 11 %b 1",
                        name, k / 2, a_ctrl, q_ctrl, alu_sub, busy, exp_a, exp_s);
            end
         end else if (k <= 9) begin
            checks++;
            if ({a_ctrl, q_ctrl, busy, done} !== {REG_SHR, REG_SHR, 2'b10}) begin
               failures++;
               $display("FAIL %s shift%0d got a=%b q=%b busy=%b done=%b want 10 10 1 0",
                        name, k / 2, a_ctrl, q_ctrl, busy, done);
            end
         end else if (k == 10) begin
            checks++;
            if ({done, busy, a_ctrl, q_ctrl} !== {2'b10, REG_HOLD, REG_HOLD}) begin
               failures++;
               $display("FAIL %s done_cycle got done=%b busy=%b a=%b q=%b want 1 0 11 11",
                        name, done, busy, a_ctrl, q_ctrl);
            end
            checks++;
            if ({a_m, q_m} !== exp_prod) begin
               failures++;
               $display("FAIL %s product got %h want %h", name, {a_m, q_m}, exp_prod);
            end
         end
         if (done === 1'b1) ndone++;
         start = (k == start_at) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (ndone !== 1) begin
         failures++;
         $display("FAIL %s done_count got %0d want 1", name, ndone);
      end
   endtask

   task automatic test_abort();
      int ndone;
      @(negedge clk);
      mplier = 4'b0110;
      mcand = 4'b0101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({a_ctrl, busy} !== {REG_SHR, 1'b1}) begin
         failures++;
         $display("FAIL abort_pre_shift2 got a=%b busy=%b want 10 1", a_ctrl, busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({a_ctrl, q_ctrl, busy, done} !== {REG_HOLD, REG_HOLD, 2'b00}) begin
         failures++;
         $display("FAIL abort_idle got a=%b q=%b busy=%b done=%b want 11 11 0 0",
                  a_ctrl, q_ctrl, busy, done);
      end
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1 || busy !== 1'b0) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone !== 0) begin
         failures++;
         $display("FAIL abort_stays_idle got %0d busy/done cycles want 0", ndone);
      end
      run_mul("after_abort", 4'b0101, 4'b0011, 8'h66, 8'h0F, 0);
   endtask

   initial begin
      test_reset();
      run_mul("mul_0101x3", 4'b0101, 4'b0011, 8'h66, 8'h0F, 0);
      run_mul("mul_0000x3", 4'b0000, 4'b0011, 8'h00, 8'h00, 0);
      run_mul("mul_1111x3", 4'b1111, 4'b0011, 8'h02, 8'hFD, 0);
      run_mul("mul_0110x5", 4'b0110, 4'b0101, 8'h48, 8'h1E, 0);
      run_mul("start_midrun", 4'b0101, 4'b0011, 8'h66, 8'h0F, 5);
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
